button_debounce: RTL and testbench

Upstream conditioning stage for the falling-edge pulse detector on the board push-button and switch inputs. It brings an asynchronous, bouncing pad signal into the `clk` domain through a synchronizer chain, then qualifies it with a stability counter and state machine. It presents a clean registered level, `sig_db`, which is wired directly to the edge detector's `sig` input.

---
 rtl/button_debounce.sv | 121 ++++++++++++
 tb/tb_button_debounce.sv | 135 +++++++++++++
 2 files changed

// File: rtl/button_debounce.sv
// button_debounce: brings a bouncing asynchronous pad signal into the clk
// domain, then only accepts a new level after it has been sampled
// STABLE_CYCLES times in a row. sig_db and busy decode registered state only.
module button_debounce #(
  parameter int   SYNC_STAGES   = 2,
  parameter int   STABLE_CYCLES = 1000,
  parameter logic INIT          = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic sig_db,
  output logic busy
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  // Encoding chosen so bit 1 is the debounced level and busy is the XOR of
  // both bits; the outputs then need no extra decode flops or logic cones.
  localparam logic [1:0] LO        = 2'b00;
  localparam logic [1:0] CHK_HI    = 2'b01;
  localparam logic [1:0] HI        = 2'b11;
  localparam logic [1:0] CHK_LO    = 2'b10;
  localparam logic [1:0] RST_STATE = INIT ? HI : LO;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   s;
  logic [1:0]             state_reg;
  logic [1:0]             state_next;
  logic [CW-1:0]          cnt_reg;
  logic [CW-1:0]          cnt_next;

  // Synchronizer chain: plain flop-to-flop, stage 0 captures the pad.
  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        // First stage samples the raw asynchronous input.
        always_ff @(posedge clk) begin
          if (rst) sync_reg[0] <= INIT;
          else     sync_reg[0] <= sig;
        end
      end else begin : g_rest
        // Later stages only shift the previous stage along.
        always_ff @(posedge clk) begin
          if (rst) sync_reg[gi] <= INIT;
          else     sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  assign s = sync_reg[SYNC_STAGES-1];

  // Next-state and stability-counter logic; any disagreeing sample restarts.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      LO: begin
        if (s) begin
          cnt_next   = CNT_ONE;
          state_next = (STABLE_CYCLES == 1) ? HI : CHK_HI;
        end else begin
          cnt_next = '0;
        end
      end
      CHK_HI: begin
        if (!s) begin
          state_next = LO;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = HI;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      HI: begin
        if (!s) begin
          cnt_next   = CNT_ONE;
          state_next = (STABLE_CYCLES == 1) ? LO : CHK_LO;
        end else begin
          cnt_next = '0;
        end
      end
      CHK_LO: begin
        if (s) begin
          state_next = HI;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = LO;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        state_next = RST_STATE;
        cnt_next   = '0;
      end
    endcase
  end

  // State and counter registers; reset wins over any transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= RST_STATE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign sig_db = state_reg[1];
  assign busy   = state_reg[1] ^ state_reg[0];

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce: one instance with STABLE_CYCLES=4 for
// the main scenarios, one with STABLE_CYCLES=1 feeding a falling-edge detector.
module tb_button_debounce;

  logic clk = 1'b0;
  logic rst;
  logic sig;
  logic sig1;
  logic sig_db;
  logic busy;
  logic sig_db1;
  logic busy1;
  logic db1_prev;
  logic ne;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  button_debounce #(.SYNC_STAGES(2), .STABLE_CYCLES(4), .INIT(1'b0)) dut (
    .clk(clk), .rst(rst), .sig(sig), .sig_db(sig_db), .busy(busy)
  );

  button_debounce #(.SYNC_STAGES(2), .STABLE_CYCLES(1), .INIT(1'b0)) dut1 (
    .clk(clk), .rst(rst), .sig(sig1), .sig_db(sig_db1), .busy(busy1)
  );

  // Downstream falling-edge detector, combinational on its input.
  always_ff @(posedge clk) begin
    if (rst) db1_prev <= 1'b0;
    else     db1_prev <= sig_db1;
  end
  assign ne = db1_prev & ~sig_db1;

  task automatic chk(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b expected=%b at %0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s = %b", tag, got);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Step sig to new_level before edge N, then check edges N..N+5.
  task automatic qualify(input logic new_level, input string name);
    sig = new_level;
    for (int k = 0; k <= 5; k++) begin
      step();
      chk($sformatf("%s_db_e%0d", name, k), sig_db, (k == 5) ? new_level : ~new_level);
      chk($sformatf("%s_busy_e%0d", name, k), busy, (k >= 2 && k <= 4));
    end
  endtask

  initial begin
    logic [9:0]  bounce_pat;
    logic [11:0] bounce_busy;
    bounce_pat  = 10'b11111_01101;   // bit i = sig before edge N+i: 1,0,1,1,0,1,1,1,1,1
    bounce_busy = 12'b0011_1011_0100; // bit k = busy after edge N+k

    rst  = 1'b1;
    sig  = 1'b1;
    sig1 = 1'b0;

    // Reset held 3 cycles with sig high.
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("rst_db_c%0d", k), sig_db, 1'b0);
      chk($sformatf("rst_busy_c%0d", k), busy, 1'b0);
    end
    rst = 1'b0;
    qualify(1'b1, "post_rst");

    // Clean release then clean press.
    qualify(1'b0, "release");
    qualify(1'b1, "press");

    // Short low glitch of 3 cycles while HI.
    sig = 1'b0;
    for (int k = 0; k <= 7; k++) begin
      step();
      if (k == 2) sig = 1'b1;
      chk($sformatf("glitch_db_e%0d", k), sig_db, 1'b1);
      chk($sformatf("glitch_busy_e%0d", k), busy, (k >= 2 && k <= 4));
    end

    // Back to LO, then bounce pattern.
    qualify(1'b0, "pre_bounce");
    for (int k = 0; k <= 11; k++) begin
      sig = (k < 10) ? bounce_pat[k] : 1'b1;
      step();
      chk($sformatf("bounce_db_e%0d", k), sig_db, (k >= 10));
      chk($sformatf("bounce_busy_e%0d", k), busy, bounce_busy[k]);
    end

    // Reset in CHK_HI with cnt=2.
    qualify(1'b0, "pre_rstchk");
    sig = 1'b1;
    for (int k = 0; k <= 3; k++) step();
    chk("rstchk_busy_before", busy, 1'b1);
    rst = 1'b1;
    step();
    chk("rstchk_db", sig_db, 1'b0);
    chk("rstchk_busy", busy, 1'b0);
    rst = 1'b0;
    qualify(1'b1, "after_rstchk");

    // STABLE_CYCLES=1: two-edge latency, no busy, one ne pulse per fall.
    sig1 = 1'b1;
    for (int k = 0; k <= 2; k++) begin
      step();
      chk($sformatf("sc1_rise_db_e%0d", k), sig_db1, (k == 2));
      chk($sformatf("sc1_rise_busy_e%0d", k), busy1, 1'b0);
      chk($sformatf("sc1_rise_ne_e%0d", k), ne, 1'b0);
    end
    sig1 = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      step();
      chk($sformatf("sc1_fall_db_e%0d", k), sig_db1, (k < 2));
      chk($sformatf("sc1_fall_busy_e%0d", k), busy1, 1'b0);
      chk($sformatf("sc1_fall_ne_e%0d", k), ne, (k == 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
